// File: rtl/lfsr_prbs_gen.sv
// Parametrised LFSR pseudo-random word generator (Fibonacci or Galois) with seed load, start/stop and a valid/ready stream.
// Latency: out_valid rises the cycle after start; each accepted beat presents the next word the following cycle (1 word/cycle).
// Backpressure: without out_ready the state, and so out_data, holds; no words are skipped.
// Optional build macro LFSR_PERIOD_CNT_EN adds period_cnt / period_len outputs.
module lfsr_prbs_gen #(
    parameter int               WIDTH        = 5,
    parameter logic [WIDTH-1:0] TAPS         = 5'b10010,
    parameter bit               GALOIS       = 1'b0,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             seed_we,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_first,
    output logic             busy,
    output logic             err_zero_seed,
    output logic             err_seed_busy
`ifdef LFSR_PERIOD_CNT_EN
    ,
    output logic [WIDTH-1:0] period_cnt,
    output logic [WIDTH-1:0] period_len
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic             ezs_q, ezs_d;
    logic             esb_q, esb_d;
    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] seed_fix;
    logic             zero_evt;
    logic             busy_evt;
    logic             accept;

    // A zero seed would lock the register up, so it is replaced by the default seed.
    assign seed_fix = (seed_in == '0) ? SEED_DEFAULT : seed_in;
    assign accept   = (fsm_q == ST_RUN) && out_ready;

    // One LFSR step; an all-zero state (only reachable by an upset) recovers to the default seed.
    always_comb begin : p_next_state
        next_state = SEED_DEFAULT;
        if (state_q != '0) begin
            if (GALOIS) begin
                next_state[0] = state_q[WIDTH-1];
                for (int i = 1; i < WIDTH; i++) begin
                    next_state[i] = state_q[i-1] ^ (state_q[WIDTH-1] & TAPS[i-1]);
                end
            end else begin
                next_state = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
            end
        end
    end

    // Control FSM: seed loads only while idle, advance only on an accepted beat.
    always_comb begin : p_ctrl
        fsm_d    = fsm_q;
        state_d  = state_q;
        seed_d   = seed_q;
        zero_evt = 1'b0;
        busy_evt = 1'b0;
        if (fsm_q == ST_IDLE) begin
            if (seed_we) begin
                seed_d   = seed_fix;
                state_d  = seed_fix;
                zero_evt = (seed_in == '0);
            end
            // stop has no meaning while idle, so start always wins here
            if (start) begin
                fsm_d = ST_RUN;
            end
        end else begin
            if (out_ready) begin
                state_d = next_state;
            end
            // stop wins over start while running; a same-cycle handshake still advances
            if (stop) begin
                fsm_d = ST_IDLE;
            end
            busy_evt = seed_we;
        end
    end

    // Sticky error flags: a new event beats a simultaneous clear.
    always_comb begin : p_err
        ezs_d = zero_evt | (ezs_q & ~err_clr);
        esb_d = busy_evt | (esb_q & ~err_clr);
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin : p_regs
        if (rst) begin
            fsm_q   <= ST_IDLE;
            state_q <= SEED_DEFAULT;
            seed_q  <= SEED_DEFAULT;
            ezs_q   <= 1'b0;
            esb_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            seed_q  <= seed_d;
            ezs_q   <= ezs_d;
            esb_q   <= esb_d;
        end
    end

    assign out_data      = state_q;
    assign out_valid     = (fsm_q == ST_RUN);
    assign busy          = (fsm_q == ST_RUN);
    assign out_first     = (state_q == seed_q);
    assign err_zero_seed = ezs_q;
    assign err_seed_busy = esb_q;

`ifdef LFSR_PERIOD_CNT_EN
    logic [WIDTH-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0] plen_q, plen_d;

    // Period measurement: the seed beat counts as zero, so the beat that wraps
    // back to the seed holds period-1 after its own increment.
    always_comb begin : p_period
        pcnt_d = pcnt_q;
        plen_d = plen_q;
        if ((fsm_q == ST_IDLE) && seed_we) begin
            pcnt_d = '0;
        end else if (accept) begin
            pcnt_d = out_first ? '0 : (pcnt_q + WIDTH'(1));
            if (next_state == seed_q) begin
                plen_d = pcnt_d + WIDTH'(1);
            end
        end
    end

    // Period counter registers.
    always_ff @(posedge clk or posedge rst) begin : p_period_regs
        if (rst) begin
            pcnt_q <= '0;
            plen_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            plen_q <= plen_d;
        end
    end

    assign period_cnt = pcnt_q;
    assign period_len = plen_q;
`endif

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Bench for lfsr_prbs_gen: a Fibonacci and a Galois instance sharing most controls.
// Cycle-level vectors for control/flag behaviour, a scoreboard for accepted beats.
// Period outputs are checked when LFSR_PERIOD_CNT_EN is defined.
module tb_lfsr_prbs_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start_g, stop, seed_we, err_clr, out_ready;
    logic [4:0] seed_in;

    logic [4:0] f_data, g_data;
    logic       f_valid, f_first, f_busy, f_ezs, f_esb;
    logic       g_valid, g_first, g_busy, g_ezs, g_esb;
`ifdef LFSR_PERIOD_CNT_EN
    logic [4:0] f_pcnt, f_plen, g_pcnt, g_plen;
`endif

    always #5 clk = ~clk;

    lfsr_prbs_gen #(.WIDTH(5), .TAPS(5'b10010), .GALOIS(1'b0), .SEED_DEFAULT(5'h01)) u_fib (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .seed_we(seed_we),
        .seed_in(seed_in), .err_clr(err_clr), .out_data(f_data), .out_valid(f_valid),
        .out_ready(out_ready), .out_first(f_first), .busy(f_busy),
        .err_zero_seed(f_ezs), .err_seed_busy(f_esb)
`ifdef LFSR_PERIOD_CNT_EN
        , .period_cnt(f_pcnt), .period_len(f_plen)
`endif
    );

    lfsr_prbs_gen #(.WIDTH(5), .TAPS(5'b10010), .GALOIS(1'b1), .SEED_DEFAULT(5'h01)) u_gal (
        .clk(clk), .rst(rst), .start(start_g), .stop(stop), .seed_we(seed_we),
        .seed_in(seed_in), .err_clr(err_clr), .out_data(g_data), .out_valid(g_valid),
        .out_ready(out_ready), .out_first(g_first), .busy(g_busy),
        .err_zero_seed(g_ezs), .err_seed_busy(g_esb)
`ifdef LFSR_PERIOD_CNT_EN
        , .period_cnt(g_pcnt), .period_len(g_plen)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference steps for x^5+x^2+1, written out per structure.
    function automatic logic [4:0] fib_next(input logic [4:0] s);
        if (s == 5'd0) return 5'd1;
        return {s[3:0], s[4] ^ s[1]};
    endfunction

    function automatic logic [4:0] gal_next(input logic [4:0] s);
        logic m;
        if (s == 5'd0) return 5'd1;
        m = s[4];
        return {s[3], s[2], s[1] ^ m, s[0], m};
    endfunction

    // Scoreboard: {first, data} of each expected accepted beat.
    logic [5:0] q_fib[$];
    logic [5:0] q_gal[$];
    logic       sb_en = 1'b0;
    logic [4:0] m_state, m_seed, g_state;

    always @(negedge clk) begin : mon
        logic [5:0] e;
        if (sb_en && f_valid && out_ready) begin
            if (q_fib.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_fib_extra got=%0h exp=none", f_data);
            end else begin
                e = q_fib.pop_front();
                chk("sb_fib_data", f_data, e[4:0]);
                chk("sb_fib_first", f_first, e[5]);
            end
        end
        if (sb_en && g_valid && out_ready) begin
            if (q_gal.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_gal_extra got=%0h exp=none", g_data);
            end else begin
                e = q_gal.pop_front();
                chk("sb_gal_data", g_data, e[4:0]);
                chk("sb_gal_first", g_first, e[5]);
            end
        end
    end

    task automatic load_seed(input logic [4:0] s);
        seed_we = 1'b1; seed_in = s;
        tick();
        seed_we = 1'b0; seed_in = 5'd0;
        m_seed = s; m_state = s; g_state = s;
    endtask

    task automatic fib_beats(input int n);
        for (int k = 0; k < n; k++) begin
            out_ready = 1'b1;
            q_fib.push_back({(m_state == m_seed), m_state});
            m_state = fib_next(m_state);
            tick();
        end
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic       s, p, w;
        logic [4:0] si;
        logic       c, r;
        logic       v;
        logic [4:0] d;
        logic       f, z, b;
    } vec_t;

    function automatic vec_t mk(input logic s, p, w, input logic [4:0] si, input logic c, r,
                                input logic v, input logic [4:0] d, input logic f, z, b);
        vec_t t;
        t.s = s; t.p = p; t.w = w; t.si = si; t.c = c; t.r = r;
        t.v = v; t.d = d; t.f = f; t.z = z; t.b = b;
        return t;
    endfunction

    vec_t       vt[21];
    logic [4:0] gtab[6];

    initial begin
        // inputs: start stop seed_we seed_in err_clr ready | valid data first ezs esb
        vt[0]  = mk(0,0,1,5'h01,0,0, 0,5'h01,1,0,0);
        vt[1]  = mk(1,0,0,5'h00,0,1, 1,5'h01,1,0,0);
        vt[2]  = mk(0,0,0,5'h00,0,1, 1,5'h02,0,0,0);
        vt[3]  = mk(0,0,0,5'h00,0,1, 1,5'h05,0,0,0);
        vt[4]  = mk(0,0,0,5'h00,0,1, 1,5'h0A,0,0,0);
        vt[5]  = mk(0,0,0,5'h00,0,1, 1,5'h15,0,0,0);
        vt[6]  = mk(0,0,0,5'h00,0,1, 1,5'h0B,0,0,0);
        vt[7]  = mk(0,0,0,5'h00,0,0, 1,5'h0B,0,0,0);
        vt[8]  = mk(0,0,0,5'h00,0,0, 1,5'h0B,0,0,0);
        vt[9]  = mk(0,0,0,5'h00,0,1, 1,5'h17,0,0,0);
        vt[10] = mk(0,0,1,5'h00,0,0, 1,5'h17,0,0,1);
        vt[11] = mk(0,1,0,5'h00,0,0, 0,5'h17,0,0,1);
        vt[12] = mk(0,0,1,5'h00,0,0, 0,5'h01,1,1,1);
        vt[13] = mk(0,0,0,5'h00,1,0, 0,5'h01,1,0,0);
        vt[14] = mk(0,0,1,5'h00,1,0, 0,5'h01,1,1,0);
        vt[15] = mk(0,0,0,5'h00,1,0, 0,5'h01,1,0,0);
        vt[16] = mk(1,0,1,5'h0A,0,0, 1,5'h0A,1,0,0);
        vt[17] = mk(0,0,0,5'h00,0,1, 1,5'h15,0,0,0);
        vt[18] = mk(1,1,0,5'h00,0,1, 0,5'h0B,0,0,0);
        vt[19] = mk(1,1,0,5'h00,0,0, 1,5'h0B,0,0,0);
        vt[20] = mk(0,1,0,5'h00,0,0, 0,5'h0B,0,0,0);
        gtab[0] = 5'h01; gtab[1] = 5'h02; gtab[2] = 5'h04;
        gtab[3] = 5'h08; gtab[4] = 5'h10; gtab[5] = 5'h05;

        // Reset values
        rst = 1'b1; start = 1'b0; start_g = 1'b0; stop = 1'b0; seed_we = 1'b0;
        seed_in = 5'd0; err_clr = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", f_valid, 1'b0);
        chk("rst_data", f_data, 5'h01);
        chk("rst_first", f_first, 1'b1);
        chk("rst_busy", f_busy, 1'b0);
        chk("rst_ezs", f_ezs, 1'b0);
        chk("rst_esb", f_esb, 1'b0);
`ifdef LFSR_PERIOD_CNT_EN
        chk("rst_plen", f_plen, 5'd0);
        chk("rst_pcnt", f_pcnt, 5'd0);
`endif
        rst = 1'b0;
        tick();

        // Cycle-level vectors on the Fibonacci instance
        for (int i = 0; i < 21; i++) begin
            start = vt[i].s; stop = vt[i].p; seed_we = vt[i].w; seed_in = vt[i].si;
            err_clr = vt[i].c; out_ready = vt[i].r;
            tick();
            chk($sformatf("vec%0d_valid", i), f_valid, vt[i].v);
            chk($sformatf("vec%0d_busy", i), f_busy, vt[i].v);
            chk($sformatf("vec%0d_data", i), f_data, vt[i].d);
            chk($sformatf("vec%0d_first", i), f_first, vt[i].f);
            chk($sformatf("vec%0d_ezs", i), f_ezs, vt[i].z);
            chk($sformatf("vec%0d_esb", i), f_esb, vt[i].b);
        end
        start = 1'b0; stop = 1'b0; seed_we = 1'b0; seed_in = 5'd0; err_clr = 1'b0; out_ready = 1'b0;

        // Stop after three beats, idle, then resume where the sequence left off
        sb_en = 1'b1;
        load_seed(5'h01);
        start = 1'b1; tick(); start = 1'b0;
        fib_beats(3);
        chk("stop_pre_data", f_data, 5'h0A);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("stop_valid", f_valid, 1'b0);
        tick();
        chk("idle_valid_a", f_valid, 1'b0);
        tick();
        chk("idle_valid_b", f_valid, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        chk("resume_valid", f_valid, 1'b1);
        chk("resume_data", f_data, 5'h0A);
        fib_beats(3);
        stop = 1'b1; tick(); stop = 1'b0;

        // Galois: full period from seed 01
        load_seed(5'h01);
        start_g = 1'b1; tick(); start_g = 1'b0;
        chk("gal_busy", g_busy, 1'b1);
        for (int i = 0; i < 31; i++) begin
            out_ready = 1'b1;
            q_gal.push_back({(g_state == 5'h01), (i < 6) ? gtab[i] : g_state});
            g_state = gal_next(g_state);
            tick();
        end
        out_ready = 1'b0;
        chk("gal_wrap_data", g_data, 5'h01);
        chk("gal_wrap_first", g_first, 1'b1);
`ifdef LFSR_PERIOD_CNT_EN
        chk("gal_plen", g_plen, 5'd31);
`endif
        chk("gal_ezs", g_ezs, 1'b0);
        chk("gal_esb", g_esb, 1'b0);
        stop = 1'b1; tick(); stop = 1'b0;

        // Fibonacci: two full periods
        load_seed(5'h01);
        start = 1'b1; tick(); start = 1'b0;
        fib_beats(31);
        chk("fib_wrap_data", f_data, 5'h01);
        chk("fib_wrap_first", f_first, 1'b1);
`ifdef LFSR_PERIOD_CNT_EN
        chk("plen_wrap1", f_plen, 5'd31);
        chk("pcnt_wrap1", f_pcnt, 5'd30);
`endif
        fib_beats(1);
`ifdef LFSR_PERIOD_CNT_EN
        chk("pcnt_first_beat", f_pcnt, 5'd0);
`endif
        fib_beats(30);
        chk("fib_wrap2_data", f_data, 5'h01);
`ifdef LFSR_PERIOD_CNT_EN
        chk("plen_wrap2", f_plen, 5'd31);
        chk("pcnt_wrap2", f_pcnt, 5'd30);
`endif

        // Asynchronous reset mid-run, between clock edges
        fib_beats(2);
        chk("pre_rst_valid", f_valid, 1'b1);
        out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", f_valid, 1'b0);
        chk("arst_busy", f_busy, 1'b0);
        chk("arst_data", f_data, 5'h01);
        chk("arst_first", f_first, 1'b1);
`ifdef LFSR_PERIOD_CNT_EN
        chk("arst_plen", f_plen, 5'd0);
`endif
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("sb_drain", q_fib.size() + q_gal.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
